wt_dcache_ctrl_bounded: RTL and testbench

- Parametrised dcache read-port controller for the write-through L1.
- Accepts one core load port and drives the tag/data read interface of the dcache memory and the request interface of the miss unit.
- Counts consecutive replays. Once the count reaches a configurable budget, it raises a priority read request so the memory arbiter cannot starve it.
- Exports per-request event pulses (hit, miss, replay, kill) and the last-returned signature width generically.

---
 rtl/wt_cache_pkg.sv | 55 +++++
 rtl/wt_dcache_ctrl_bounded_replay_budget.sv | 29 ++
 rtl/wt_dcache_ctrl_bounded.sv | 261 ++++++++++++++++++++++++++
 tb/tb_wt_dcache_ctrl_bounded.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared types and geometry for the write-through L1 dcache read-port controller.
// Holds the request/response structs, read FSM states and the cacheable-region check.
package wt_cache_pkg;

  localparam int unsigned DCACHE_SET_ASSOC    = 4;
  localparam int unsigned CACHE_ID_WIDTH      = 2;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
  localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
  localparam int unsigned DCACHE_TAG_WIDTH    = 44;
  localparam int unsigned DCACHE_MAX_REPLAY_W = 4;
  localparam int unsigned DCACHE_SIG_MAX_W    = 14;

  typedef struct packed {
    logic [63:0] cached_base;
    logic [63:0] cached_len;
  } ariane_cfg_t;

  localparam ariane_cfg_t ArianeDefaultConfig = '{
    cached_base: 64'h0000_0000_8000_0000,
    cached_len:  64'h0000_0000_4000_0000
  };

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic                          tag_valid;
    logic                          data_req;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic [DCACHE_SIG_MAX_W-1:0]   signature;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MISS_REQ,
    MISS_WAIT,
    REPLAY_REQ,
    REPLAY_READ,
    KILL_MISS_ACK,
    KILL_MISS
  } dcache_rd_state_e;

  function automatic logic is_inside_cacheable_regions(ariane_cfg_t cfg, logic [63:0] addr);
    return (addr >= cfg.cached_base) && (addr < (cfg.cached_base + cfg.cached_len));
  endfunction

endpackage

// File: rtl/wt_dcache_ctrl_bounded_replay_budget.sv
// Consecutive-replay counter; flags a priority read once the replay budget is spent.
module wt_dcache_replay_budget
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxReplays = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  input  logic replay_req_i,
  output logic prio_o
);

  logic [DCACHE_MAX_REPLAY_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign prio_o = replay_req_i && (cnt_q >= DCACHE_MAX_REPLAY_W'(MaxReplays));

endmodule

// File: rtl/wt_dcache_ctrl_bounded.sv
// Load-port controller for the write-through L1 dcache with bounded-replay read priority.
// Define WT_DCACHE_CTRL_PERF_EN to add saturating hit/miss/replay counters (perf_clr_i, perf_cnt_o).
module wt_dcache_ctrl_bounded
  import wt_cache_pkg::*;
#(
  parameter logic [CACHE_ID_WIDTH-1:0] RdTxId     = CACHE_ID_WIDTH'(1),
  parameter ariane_cfg_t               ArianeCfg  = ArianeDefaultConfig,
  parameter int unsigned               SigWidth   = 14,
  parameter int unsigned               NumWays    = DCACHE_SET_ASSOC,
  parameter int unsigned               MaxReplays = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cache_en_i,
  input  dcache_req_i_t                  req_port_i,
  output dcache_req_o_t                  req_port_o,
  output logic                           miss_req_o,
  input  logic                           miss_ack_i,
  input  logic                           miss_replay_i,
  input  logic                           miss_rtrn_vld_i,
  output logic [63:0]                    miss_paddr_o,
  output logic                           miss_nc_o,
  output logic [2:0]                     miss_size_o,
  output logic [CACHE_ID_WIDTH-1:0]      miss_id_o,
  output logic [NumWays-1:0]             miss_vld_bits_o,
  output logic [NumWays-1:0]             miss_ever_hit_o,
  output logic [$clog2(NumWays)-1:0]     miss_rep_way_o,
  output logic                           miss_rep_way_vld_o,
  output logic [SigWidth-1:0]            miss_signature_o,
  input  logic                           srrip_conflict_i,
  input  logic                           wr_cl_vld_i,
  output logic                           rd_req_o,
  output logic                           rd_prio_o,
  input  logic                           rd_ack_i,
  output logic [DCACHE_TAG_WIDTH-1:0]    rd_tag_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_o,
  output logic                           rd_tag_only_o,
  input  logic [63:0]                    rd_data_i,
  input  logic [NumWays-1:0]             rd_vld_bits_i,
  input  logic [NumWays-1:0]             rd_ever_hit_i,
  input  logic [NumWays-1:0]             rd_hit_oh_i,
  input  logic [$clog2(NumWays)-1:0]     rd_rep_way_i,
  input  logic                           rd_rep_way_vld_i,
  output logic [SigWidth-1:0]            signature_o,
  output logic                           evt_hit_o,
  output logic                           evt_miss_o,
  output logic                           evt_replay_o,
  output logic                           evt_kill_o
`ifdef WT_DCACHE_CTRL_PERF_EN
  ,
  input  logic                           perf_clr_i,
  output logic [95:0]                    perf_cnt_o
`endif
);

  dcache_rd_state_e state_d, state_q;

  logic [DCACHE_TAG_WIDTH-1:0]    tag_d, tag_q;
  logic [DCACHE_CL_IDX_WIDTH-1:0] idx_d, idx_q;
  logic [DCACHE_OFFSET_WIDTH-1:0] off_d, off_q;
  logic [1:0]                     size_d, size_q;
  logic [SigWidth-1:0]            sig_d, sig_q;
  logic [NumWays-1:0]             vld_q, ever_hit_q;
  logic [$clog2(NumWays)-1:0]     rep_way_q;
  logic                           rep_way_vld_q;
  logic                           rd_req_q, rd_ack_q;
  logic                           data_gnt, data_rvalid;
  logic                           cnt_inc, hit_clr, tag_seen;

  assign tag_seen = (state_q == READ) && req_port_i.tag_valid;

  assign idx_d  = data_gnt ? req_port_i.address_index[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH] : idx_q;
  assign off_d  = data_gnt ? req_port_i.address_index[DCACHE_OFFSET_WIDTH-1:0] : off_q;
  assign size_d = data_gnt ? req_port_i.data_size : size_q;
  assign tag_d  = tag_seen ? req_port_i.address_tag : tag_q;
  assign sig_d  = tag_seen ? req_port_i.signature[SigWidth-1:0] : sig_q;

  always_comb begin
    state_d      = state_q;
    rd_req_o     = 1'b0;
    miss_req_o   = 1'b0;
    data_gnt     = 1'b0;
    data_rvalid  = 1'b0;
    evt_hit_o    = 1'b0;
    evt_miss_o   = 1'b0;
    evt_replay_o = 1'b0;
    evt_kill_o   = 1'b0;
    cnt_inc      = 1'b0;
    hit_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_port_i.data_req) begin
          rd_req_o = 1'b1;
          if (rd_ack_i) begin
            data_gnt = 1'b1;
            state_d  = READ;
          end
        end
      end
      READ, REPLAY_READ: begin
        rd_req_o = 1'b1;
        if (req_port_i.kill_req) begin
          data_rvalid = 1'b1;
          evt_kill_o  = 1'b1;
          state_d     = IDLE;
        end else if ((state_q == REPLAY_READ) || req_port_i.tag_valid) begin
          // a lost read port last cycle means the tag/data outputs may be stale
          if (wr_cl_vld_i || srrip_conflict_i || !rd_ack_q) begin
            state_d      = REPLAY_REQ;
            cnt_inc      = 1'b1;
            evt_replay_o = 1'b1;
          end else if ((|rd_hit_oh_i) && cache_en_i) begin
            data_rvalid = 1'b1;
            evt_hit_o   = 1'b1;
            hit_clr     = 1'b1;
            state_d     = IDLE;
            if (req_port_i.data_req && rd_ack_i) begin
              data_gnt = 1'b1;
              state_d  = READ;
            end
          end else begin
            state_d    = MISS_REQ;
            evt_miss_o = 1'b1;
          end
        end
      end
      MISS_REQ: begin
        miss_req_o = 1'b1;
        if (req_port_i.kill_req) begin
          data_rvalid = 1'b1;
          evt_kill_o  = 1'b1;
          state_d     = miss_ack_i ? KILL_MISS : KILL_MISS_ACK;
        end else if (miss_replay_i) begin
          state_d      = REPLAY_REQ;
          cnt_inc      = 1'b1;
          evt_replay_o = 1'b1;
        end else if (miss_ack_i) begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (req_port_i.kill_req) begin
          data_rvalid = 1'b1;
          evt_kill_o  = 1'b1;
          state_d     = miss_rtrn_vld_i ? IDLE : KILL_MISS;
        end else if (miss_rtrn_vld_i) begin
          data_rvalid = 1'b1;
          state_d     = IDLE;
        end
      end
      REPLAY_REQ: begin
        rd_req_o = 1'b1;
        if (req_port_i.kill_req) begin
          data_rvalid = 1'b1;
          evt_kill_o  = 1'b1;
          state_d     = IDLE;
        end else if (rd_ack_i) begin
          state_d = REPLAY_READ;
        end
      end
      KILL_MISS_ACK: begin
        miss_req_o = 1'b1;
        if (miss_replay_i) begin
          state_d = IDLE;
        end else if (miss_ack_i) begin
          state_d = KILL_MISS;
        end
      end
      KILL_MISS: begin
        if (miss_rtrn_vld_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  wt_dcache_replay_budget #(
    .MaxReplays(MaxReplays)
  ) u_budget (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .inc_i        (cnt_inc),
    .clr_i        (hit_clr || (state_d == IDLE)),
    .replay_req_i (state_q == REPLAY_REQ),
    .prio_o       (rd_prio_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      idx_q         <= '0;
      off_q         <= '0;
      size_q        <= '0;
      sig_q         <= '0;
      vld_q         <= '0;
      ever_hit_q    <= '0;
      rep_way_q     <= '0;
      rep_way_vld_q <= 1'b0;
      rd_req_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      size_q   <= size_d;
      sig_q    <= sig_d;
      rd_req_q <= rd_req_o;
      rd_ack_q <= rd_ack_i;
      if (rd_req_q) begin
        vld_q         <= rd_vld_bits_i;
        ever_hit_q    <= rd_ever_hit_i;
        rep_way_q     <= rd_rep_way_i;
        rep_way_vld_q <= rd_rep_way_vld_i;
      end
    end
  end

  assign req_port_o = '{data_gnt: data_gnt, data_rvalid: data_rvalid, data_rdata: rd_data_i};

  assign rd_tag_o      = tag_d;
  assign rd_idx_o      = idx_d;
  assign rd_off_o      = off_d;
  assign rd_tag_only_o = 1'b0;
  assign signature_o   = sig_d;

  assign miss_paddr_o       = 64'({tag_q, idx_q, off_q});
  assign miss_nc_o          = ~cache_en_i |
                              ~is_inside_cacheable_regions(ArianeCfg, 64'({tag_q, {DCACHE_INDEX_WIDTH{1'b0}}}));
  assign miss_size_o        = miss_nc_o ? {1'b0, size_q} : 3'b111;
  assign miss_id_o          = RdTxId;
  assign miss_vld_bits_o    = vld_q;
  assign miss_ever_hit_o    = ever_hit_q;
  assign miss_rep_way_o     = rep_way_q;
  assign miss_rep_way_vld_o = rep_way_vld_q;
  assign miss_signature_o   = sig_q;

`ifdef WT_DCACHE_CTRL_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q, perf_replay_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_hit_q    <= '0;
      perf_miss_q   <= '0;
      perf_replay_q <= '0;
    end else if (perf_clr_i) begin
      perf_hit_q    <= '0;
      perf_miss_q   <= '0;
      perf_replay_q <= '0;
    end else begin
      if (evt_hit_o && (perf_hit_q != '1))       perf_hit_q    <= perf_hit_q + 1'b1;
      if (evt_miss_o && (perf_miss_q != '1))     perf_miss_q   <= perf_miss_q + 1'b1;
      if (evt_replay_o && (perf_replay_q != '1)) perf_replay_q <= perf_replay_q + 1'b1;
    end
  end

  assign perf_cnt_o = {perf_replay_q, perf_miss_q, perf_hit_q};
`endif

endmodule

// File: tb/tb_wt_dcache_ctrl_bounded.sv
// Directed self-checking bench for wt_dcache_ctrl_bounded (default MaxReplays=4).
module tb_wt_dcache_ctrl_bounded;
  import wt_cache_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic cache_en_i;
  dcache_req_i_t req;
  dcache_req_o_t rsp;
  logic miss_req_o, miss_ack_i, miss_replay_i, miss_rtrn_vld_i;
  logic [63:0] miss_paddr_o;
  logic miss_nc_o;
  logic [2:0] miss_size_o;
  logic [CACHE_ID_WIDTH-1:0] miss_id_o;
  logic [3:0] miss_vld_bits_o, miss_ever_hit_o;
  logic [1:0] miss_rep_way_o;
  logic miss_rep_way_vld_o;
  logic [13:0] miss_signature_o, signature_o;
  logic srrip_conflict_i, wr_cl_vld_i;
  logic rd_req_o, rd_prio_o, rd_ack_i, rd_tag_only_o;
  logic [DCACHE_TAG_WIDTH-1:0] rd_tag_o;
  logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_o;
  logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_o;
  logic [63:0] rd_data_i;
  logic [3:0] rd_vld_bits_i, rd_ever_hit_i, rd_hit_oh_i;
  logic [1:0] rd_rep_way_i;
  logic rd_rep_way_vld_i;
  logic evt_hit_o, evt_miss_o, evt_replay_o, evt_kill_o;
`ifdef WT_DCACHE_CTRL_PERF_EN
  logic perf_clr_i = 1'b0;
  logic [95:0] perf_cnt_o;
`endif

  int n_run = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  wt_dcache_ctrl_bounded dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cache_en_i(cache_en_i),
    .req_port_i(req), .req_port_o(rsp),
    .miss_req_o(miss_req_o), .miss_ack_i(miss_ack_i), .miss_replay_i(miss_replay_i),
    .miss_rtrn_vld_i(miss_rtrn_vld_i), .miss_paddr_o(miss_paddr_o), .miss_nc_o(miss_nc_o),
    .miss_size_o(miss_size_o), .miss_id_o(miss_id_o), .miss_vld_bits_o(miss_vld_bits_o),
    .miss_ever_hit_o(miss_ever_hit_o), .miss_rep_way_o(miss_rep_way_o),
    .miss_rep_way_vld_o(miss_rep_way_vld_o), .miss_signature_o(miss_signature_o),
    .srrip_conflict_i(srrip_conflict_i), .wr_cl_vld_i(wr_cl_vld_i),
    .rd_req_o(rd_req_o), .rd_prio_o(rd_prio_o), .rd_ack_i(rd_ack_i),
    .rd_tag_o(rd_tag_o), .rd_idx_o(rd_idx_o), .rd_off_o(rd_off_o),
    .rd_tag_only_o(rd_tag_only_o), .rd_data_i(rd_data_i), .rd_vld_bits_i(rd_vld_bits_i),
    .rd_ever_hit_i(rd_ever_hit_i), .rd_hit_oh_i(rd_hit_oh_i), .rd_rep_way_i(rd_rep_way_i),
    .rd_rep_way_vld_i(rd_rep_way_vld_i), .signature_o(signature_o),
    .evt_hit_o(evt_hit_o), .evt_miss_o(evt_miss_o), .evt_replay_o(evt_replay_o),
    .evt_kill_o(evt_kill_o)
`ifdef WT_DCACHE_CTRL_PERF_EN
    , .perf_clr_i(perf_clr_i), .perf_cnt_o(perf_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic zero_inputs();
    req = '0;
    cache_en_i = 1'b1;
    miss_ack_i = 1'b0; miss_replay_i = 1'b0; miss_rtrn_vld_i = 1'b0;
    srrip_conflict_i = 1'b0; wr_cl_vld_i = 1'b0;
    rd_ack_i = 1'b0; rd_data_i = '0;
    rd_vld_bits_i = '0; rd_ever_hit_i = '0; rd_hit_oh_i = '0;
    rd_rep_way_i = '0; rd_rep_way_vld_i = 1'b0;
  endtask

  // Issue a load from IDLE; rd_ack_i is high so it is granted in this cycle.
  task automatic grant(input logic [11:0] index, input logic [1:0] size);
    req.data_req = 1'b1; req.address_index = index; req.data_size = size;
    tick();
    req.data_req = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_run++; if (rd_req_o !== 1'b0 || miss_req_o !== 1'b0 || rd_prio_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: rd_req=%b miss_req=%b prio=%b required 000", rd_req_o, miss_req_o, rd_prio_o); end
    n_run++; if (rsp !== '0 || miss_paddr_o !== 64'h0 || miss_signature_o !== 14'h0) begin
      n_fail++; $display("FAIL reset_data: rsp=%h paddr=%h sig=%h required 0", rsp, miss_paddr_o, miss_signature_o); end
    n_run++; if (dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d required IDLE", dut.state_q); end
  endtask

  task automatic test_hit();
    req.data_req = 1'b1; req.address_index = 12'h123; req.data_size = 2'b11; #1;
    n_run++; if (rd_req_o !== 1'b1 || rsp.data_gnt !== 1'b1 || rd_idx_o !== 8'h12 || rd_off_o !== 4'h3) begin
      n_fail++; $display("FAIL hit_grant: rd_req=%b gnt=%b idx=%h off=%h required 1 1 12 3", rd_req_o, rsp.data_gnt, rd_idx_o, rd_off_o); end
    tick();
    req.data_req = 1'b0; req.tag_valid = 1'b1; req.address_tag = 44'h80000; rd_hit_oh_i = 4'b0010;
    rd_data_i = 64'hdead_beef_0000_1111; #1;
    n_run++; if (rsp.data_rvalid !== 1'b1 || evt_hit_o !== 1'b1 || rsp.data_rdata !== 64'hdead_beef_0000_1111) begin
      n_fail++; $display("FAIL hit_rvalid: rvalid=%b evt_hit=%b rdata=%h required 1 1 deadbeef00001111", rsp.data_rvalid, evt_hit_o, rsp.data_rdata); end
    n_run++; if (rd_tag_o !== 44'h80000) begin
      n_fail++; $display("FAIL hit_tag: got %h required 80000", rd_tag_o); end
    tick();
    req.tag_valid = 1'b0; rd_hit_oh_i = '0; #1;
    n_run++; if (dut.state_q !== IDLE || rsp.data_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL hit_idle: state=%0d rvalid=%b required IDLE 0", dut.state_q, rsp.data_rvalid); end
  endtask

  task automatic test_miss();
    grant(12'h123, 2'b10);
    req.tag_valid = 1'b1; req.address_tag = 44'h80000; req.signature = 14'h1abc; rd_hit_oh_i = '0; #1;
    n_run++; if (evt_miss_o !== 1'b1 || miss_req_o !== 1'b0 || signature_o !== 14'h1abc) begin
      n_fail++; $display("FAIL miss_detect: evt_miss=%b miss_req=%b sig=%h required 1 0 1abc", evt_miss_o, miss_req_o, signature_o); end
    tick();
    req.tag_valid = 1'b0; req.signature = '0; #1;
    n_run++; if (miss_req_o !== 1'b1 || miss_size_o !== 3'b111 || miss_nc_o !== 1'b0) begin
      n_fail++; $display("FAIL miss_req: req=%b size=%b nc=%b required 1 111 0", miss_req_o, miss_size_o, miss_nc_o); end
    n_run++; if (miss_paddr_o !== 64'h8000_0123 || miss_signature_o !== 14'h1abc || miss_vld_bits_o !== 4'b1011) begin
      n_fail++; $display("FAIL miss_fields: paddr=%h sig=%h vld=%b required 80000123 1abc 1011", miss_paddr_o, miss_signature_o, miss_vld_bits_o); end
    miss_ack_i = 1'b1;
    tick();
    miss_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_run++; if (rsp.data_rvalid !== 1'b0 || miss_req_o !== 1'b0) begin
        n_fail++; $display("FAIL miss_wait%0d: rvalid=%b miss_req=%b required 0 0", i, rsp.data_rvalid, miss_req_o); end
      tick();
    end
    miss_rtrn_vld_i = 1'b1; #1;
    n_run++; if (rsp.data_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL miss_rtrn: rvalid=%b required 1", rsp.data_rvalid); end
    tick();
    miss_rtrn_vld_i = 1'b0; #1;
    n_run++; if (dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL miss_idle: state=%0d required IDLE", dut.state_q); end
  endtask

  task automatic test_nc_kill();
    cache_en_i = 1'b0;
    grant(12'h045, 2'b01);
    req.tag_valid = 1'b1; req.address_tag = 44'h80000; rd_hit_oh_i = 4'b0001; #1;
    n_run++; if (evt_miss_o !== 1'b1 || evt_hit_o !== 1'b0 || rsp.data_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL nc_miss: evt_miss=%b evt_hit=%b rvalid=%b required 1 0 0", evt_miss_o, evt_hit_o, rsp.data_rvalid); end
    tick();
    req.tag_valid = 1'b0; rd_hit_oh_i = '0; #1;
    n_run++; if (miss_nc_o !== 1'b1 || miss_size_o !== 3'b001) begin
      n_fail++; $display("FAIL nc_fields: nc=%b size=%b required 1 001", miss_nc_o, miss_size_o); end
    req.kill_req = 1'b1; #1;
    n_run++; if (rsp.data_rvalid !== 1'b1 || miss_req_o !== 1'b1) begin
      n_fail++; $display("FAIL kill_missreq: rvalid=%b miss_req=%b required 1 1", rsp.data_rvalid, miss_req_o); end
    tick();
    req.kill_req = 1'b0; cache_en_i = 1'b1; miss_replay_i = 1'b1; #1;
    n_run++; if (dut.state_q !== KILL_MISS_ACK || rsp.data_rvalid !== 1'b0 || miss_req_o !== 1'b1) begin
      n_fail++; $display("FAIL kill_ack_state: state=%0d rvalid=%b miss_req=%b required KILL_MISS_ACK 0 1", dut.state_q, rsp.data_rvalid, miss_req_o); end
    tick();
    miss_replay_i = 1'b0; #1;
    n_run++; if (dut.state_q !== IDLE || rsp.data_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL kill_done: state=%0d rvalid=%b required IDLE 0", dut.state_q, rsp.data_rvalid); end
  endtask

  task automatic test_kill_read();
    grant(12'h300, 2'b11);
    req.kill_req = 1'b1; #1;
    n_run++; if (rsp.data_rvalid !== 1'b1 || evt_kill_o !== 1'b1 || evt_hit_o !== 1'b0) begin
      n_fail++; $display("FAIL kill_read: rvalid=%b evt_kill=%b evt_hit=%b required 1 1 0", rsp.data_rvalid, evt_kill_o, evt_hit_o); end
    tick();
    req.kill_req = 1'b0; #1;
    n_run++; if (dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL kill_read_idle: state=%0d required IDLE", dut.state_q); end
  endtask

  task automatic test_replay_budget();
    wr_cl_vld_i = 1'b1; rd_hit_oh_i = 4'b0001;
    grant(12'h200, 2'b11);
    req.tag_valid = 1'b1; req.address_tag = 44'h80001; #1;
    n_run++; if (evt_replay_o !== 1'b1 || rsp.data_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL replay_first: evt_replay=%b rvalid=%b required 1 0", evt_replay_o, rsp.data_rvalid); end
    tick();
    req.tag_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_run++; if (rd_req_o !== 1'b1 || rd_prio_o !== (k >= 4)) begin
        n_fail++; $display("FAIL replay_prio%0d: rd_req=%b prio=%b required 1 %b", k, rd_req_o, rd_prio_o, (k >= 4)); end
      tick();
      if (k == 5) wr_cl_vld_i = 1'b0;
      #1;
      if (k < 5) begin
        n_run++; if (evt_replay_o !== 1'b1) begin
          n_fail++; $display("FAIL replay_again%0d: evt_replay=%b required 1", k, evt_replay_o); end
      end else begin
        n_run++; if (rsp.data_rvalid !== 1'b1 || evt_hit_o !== 1'b1) begin
          n_fail++; $display("FAIL replay_hit: rvalid=%b evt_hit=%b required 1 1", rsp.data_rvalid, evt_hit_o); end
      end
      tick();
    end
    // budget must have restarted: the next replay is not prioritised
    wr_cl_vld_i = 1'b1;
    grant(12'h204, 2'b11);
    req.tag_valid = 1'b1;
    tick();
    req.tag_valid = 1'b0; #1;
    n_run++; if (dut.state_q !== REPLAY_REQ || rd_prio_o !== 1'b0) begin
      n_fail++; $display("FAIL replay_cleared: state=%0d prio=%b required REPLAY_REQ 0", dut.state_q, rd_prio_o); end
    tick();
    wr_cl_vld_i = 1'b0; #1;
    n_run++; if (rsp.data_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL replay_cleared_hit: rvalid=%b required 1", rsp.data_rvalid); end
    tick();
    rd_hit_oh_i = '0;
  endtask

  task automatic test_lost_ack_and_srrip();
    grant(12'h0a0, 2'b11);
    rd_ack_i = 1'b0;
    tick();
    rd_ack_i = 1'b1; req.tag_valid = 1'b1; rd_hit_oh_i = 4'b0010; #1;
    n_run++; if (evt_replay_o !== 1'b1 || rsp.data_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL lost_ack: evt_replay=%b rvalid=%b required 1 0", evt_replay_o, rsp.data_rvalid); end
    tick();
    req.tag_valid = 1'b0;
    tick();
    srrip_conflict_i = 1'b1; #1;
    n_run++; if (evt_replay_o !== 1'b1 || evt_hit_o !== 1'b0) begin
      n_fail++; $display("FAIL srrip_replay: evt_replay=%b evt_hit=%b required 1 0", evt_replay_o, evt_hit_o); end
    tick();
    srrip_conflict_i = 1'b0;
    tick();
    #1;
    n_run++; if (rsp.data_rvalid !== 1'b1 || evt_hit_o !== 1'b1) begin
      n_fail++; $display("FAIL srrip_hit: rvalid=%b evt_hit=%b required 1 1", rsp.data_rvalid, evt_hit_o); end
    tick();
    rd_hit_oh_i = '0;
  endtask

  task automatic test_back_to_back();
    grant(12'h010, 2'b11);
    req.tag_valid = 1'b1; req.address_tag = 44'h80002; rd_hit_oh_i = 4'b0010;
    req.data_req = 1'b1; req.address_index = 12'h020; #1;
    n_run++; if (rsp.data_rvalid !== 1'b1 || rsp.data_gnt !== 1'b1 || rd_idx_o !== 8'h02) begin
      n_fail++; $display("FAIL b2b_hit_gnt: rvalid=%b gnt=%b idx=%h required 1 1 02", rsp.data_rvalid, rsp.data_gnt, rd_idx_o); end
    tick();
    req.data_req = 1'b0; #1;
    n_run++; if (dut.state_q !== READ || rsp.data_rvalid !== 1'b1 || rd_idx_o !== 8'h02) begin
      n_fail++; $display("FAIL b2b_second: state=%0d rvalid=%b idx=%h required READ 1 02", dut.state_q, rsp.data_rvalid, rd_idx_o); end
    tick();
    req.tag_valid = 1'b0; rd_hit_oh_i = '0; #1;
    n_run++; if (dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL b2b_idle: state=%0d required IDLE", dut.state_q); end
  endtask

  task automatic test_reset_miss_wait();
    grant(12'h150, 2'b11);
    req.tag_valid = 1'b1; req.address_tag = 44'h80003;
    tick();
    req.tag_valid = 1'b0; miss_replay_i = 1'b1;
    tick();
    miss_replay_i = 1'b0;
    tick();
    tick();
    miss_ack_i = 1'b1;
    tick();
    miss_ack_i = 1'b0; #1;
    n_run++; if (dut.state_q !== MISS_WAIT || dut.u_budget.cnt_q !== 4'd1) begin
      n_fail++; $display("FAIL pre_reset: state=%0d cnt=%0d required MISS_WAIT 1", dut.state_q, dut.u_budget.cnt_q); end
    zero_inputs();
    rst_ni = 1'b0; #1;
    n_run++; if (rd_req_o !== 1'b0 || miss_req_o !== 1'b0 || rd_prio_o !== 1'b0 || rsp !== '0 ||
                 {evt_hit_o, evt_miss_o, evt_replay_o, evt_kill_o} !== 4'b0) begin
      n_fail++; $display("FAIL async_reset_out: rd_req=%b miss_req=%b prio=%b rsp=%h evts=%b required all 0",
                         rd_req_o, miss_req_o, rd_prio_o, rsp, {evt_hit_o, evt_miss_o, evt_replay_o, evt_kill_o}); end
    n_run++; if (dut.state_q !== IDLE || dut.u_budget.cnt_q !== 4'd0 || miss_paddr_o !== 64'h0) begin
      n_fail++; $display("FAIL async_reset_state: state=%0d cnt=%0d paddr=%h required IDLE 0 0", dut.state_q, dut.u_budget.cnt_q, miss_paddr_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, required completion before 20000");
    $fatal(1, "timeout");
  end

  initial begin
    zero_inputs();
    rst_ni = 1'b0;
    #12;
    test_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd_ack_i = 1'b1; rd_vld_bits_i = 4'b1011;
    tick();
    test_hit();
    test_miss();
    test_nc_kill();
    test_kill_read();
    test_replay_budget();
    test_lost_ack_and_srrip();
    test_back_to_back();
    test_reset_miss_wait();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
